// File: rtl/control_bank_fsm.sv
// control_bank_fsm
//   Bank of NCH control channels. Each channel owns a staging register,
//   a committed data register and a live (pass-through) field. One channel
//   is "active" at a time: normal cycles load its stage/live from the inputs,
//   and a rising edge of enter commits stage -> committed (active channel, or
//   every channel when commit_all_i is set). Select cycles change the active
//   channel and suppress all stage/live/commit updates.
//
// Ports
//   clock_i, reset_i     clock, synchronous active-high reset
//   sel_valid_i/sel_idx_i request to change the active channel
//   data_in_i, live_in_i candidate data / live bits for the active channel
//   enter_i              commit request (rising edge acted on)
//   commit_all_i         0: commit active channel, 1: commit all channels
//   ch_ctrl_o            per-channel {live, committed}, channel k at [k*RW +: RW]
//   status_o             registered {active idx, active channel record}
//   dirty_o              stage[active] != committed[active]
//   commit_pulse_o       one-cycle strobe the cycle after a commit

module control_bank_ch #(
    parameter int DW = 8,
    parameter int LW = 2
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          wr_en_i,
    input  logic          commit_i,
    input  logic [DW-1:0] data_i,
    input  logic [LW-1:0] live_i,
    output logic [DW-1:0] stage_o,
    output logic [DW-1:0] committed_o,
    output logic [LW-1:0] live_o
);
    logic [DW-1:0] stage_q, committed_q;
    logic [LW-1:0] live_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stage_q     <= '0;
            committed_q <= '0;
            live_q      <= '0;
        end else begin
            if (wr_en_i) begin
                stage_q <= data_i;
                live_q  <= live_i;
            end
            // Commits take the stage value held before this edge.
            if (commit_i) committed_q <= stage_q;
        end
    end

    assign stage_o     = stage_q;
    assign committed_o = committed_q;
    assign live_o      = live_q;
endmodule

module control_bank_fsm #(
    parameter int NCH = 2,
    parameter int DW  = 8,
    parameter int LW  = 2,
    localparam int CW = $clog2(NCH),
    localparam int RW = DW + LW
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              sel_valid_i,
    input  logic [CW-1:0]     sel_idx_i,
    input  logic [DW-1:0]     data_in_i,
    input  logic [LW-1:0]     live_in_i,
    input  logic              enter_i,
    input  logic              commit_all_i,
    output logic [NCH*RW-1:0] ch_ctrl_o,
    output logic [CW+RW-1:0]  status_o,
    output logic              dirty_o,
    output logic              commit_pulse_o
);
    logic [NCH-1:0][DW-1:0] stage, committed;
    logic [NCH-1:0][LW-1:0] live;
    logic [NCH-1:0]         wr_en, commit;

    logic [CW-1:0]    active_q, active_d;
    logic             enter_q;
    logic [CW+RW-1:0] status_q, status_d;
    logic             pulse_q, pulse_d;
    logic             enter_rise, do_commit;

    always_comb begin
        enter_rise = enter_i & ~enter_q;
        // A rising edge that lands on a select cycle is consumed silently.
        do_commit  = ~sel_valid_i & enter_rise;
        active_d   = active_q;
        if (sel_valid_i && (int'(sel_idx_i) < NCH)) active_d = sel_idx_i;
        pulse_d    = do_commit;
        status_d   = {active_q, live[active_q], committed[active_q]};
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            active_q <= '0;
            enter_q  <= 1'b0;
            status_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            active_q <= active_d;
            enter_q  <= enter_i;
            status_q <= status_d;
            pulse_q  <= pulse_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign wr_en[k] = ~sel_valid_i & (active_q == CW'(k));
        assign commit[k] = do_commit & (commit_all_i | (active_q == CW'(k)));
        assign ch_ctrl_o[k*RW +: RW] = {live[k], committed[k]};

        control_bank_ch #(.DW(DW), .LW(LW)) u_ch (
            .clock_i    (clock_i),
            .reset_i    (reset_i),
            .wr_en_i    (wr_en[k]),
            .commit_i   (commit[k]),
            .data_i     (data_in_i),
            .live_i     (live_in_i),
            .stage_o    (stage[k]),
            .committed_o(committed[k]),
            .live_o     (live[k])
        );
    end

    assign dirty_o        = stage[active_q] != committed[active_q];
    assign status_o       = status_q;
    assign commit_pulse_o = pulse_q;
endmodule

// File: doc/control_bank_fsm.md
CONTROL_BANK_FSM -- requirements
Module: control_bank_fsm

Interface
REQ-001 Parameter NCH, default 2, number of control channels (NCH >= 2).
REQ-002 Parameter DW, default 8, width of committed data field per channel.
REQ-003 Parameter LW, default 2, width of live (pass-through) field per channel.
REQ-004 Local CW = clog2(NCH), channel index width; RW = DW+LW, per-channel record width.
REQ-005 clock  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sel_valid  in  1  request to change active channel this cycle.
REQ-008 sel_idx  in  CW  requested active channel index.
REQ-009 data_in  in  DW  candidate data for the active channel.
REQ-010 live_in  in  LW  live bits for the active channel.
REQ-011 enter  in  1  commit request, level; acted on at its rising edge only.
REQ-012 commit_all  in  1  mode: 0 = commit the active channel only, 1 = commit every channel.
REQ-013 ch_ctrl  out  NCH*RW  channel k record at [k*RW +: RW] = {live[LW-1:0], committed data[DW-1:0]}.
REQ-014 status  out  CW+RW  registered {active idx, active channel record}.
REQ-015 dirty  out  1  stage of active channel differs from its committed data.
REQ-016 commit_pulse  out  1  one-cycle strobe, high the cycle after any commit.

Function
REQ-017 Per-channel registers: stage (DW), committed (DW), live (LW); plus active (CW) and enter_d (1).
REQ-018 Priority per cycle: reset > sel_valid > normal operation.
REQ-019 sel_valid=1, sel_idx<NCH: active <= sel_idx next cycle; no stage, live or commit update that cycle.
REQ-020 sel_valid=1, sel_idx>=NCH: active holds; cycle otherwise treated as a select cycle (no updates).
REQ-021 Normal cycle: stage[active] <= data_in; live[active] <= live_in; other channels' stage/live hold.
REQ-022 enter_d <= enter every cycle, including select cycles; edge = enter & ~enter_d.
REQ-023 Edge in normal cycle, commit_all=0: committed[active] <= stage[active] (value registered before this edge, i.e. data_in from the prior cycle).
REQ-024 Edge in normal cycle, commit_all=1: committed[k] <= stage[k] for all k.
REQ-025 Enter held high: exactly one commit per rising edge; no repeat commits.
REQ-026 Edge coinciding with a select cycle: edge consumed, no commit, no commit_pulse.
REQ-027 commit_pulse <= 1 the cycle after a commit, else 0.
REQ-028 status <= {active, live[active], committed[active]} every cycle; one-cycle lag vs. internal state.
REQ-029 dirty combinational: stage[active] != committed[active].
REQ-030 ch_ctrl combinational view of live and committed registers; stage never appears on ch_ctrl.

Reset
REQ-031 reset=1: stage, committed, live, active, enter_d, status, commit_pulse all cleared to 0 on the next edge.
REQ-032 Reset mid-press (enter high through reset release): enter_d=0 after reset, so an enter still high after release commits once (zero-cleared stage unless data_in was sampled).
REQ-033 Reset has priority over coincident sel_valid and enter edge.

Verification (NCH=2, DW=8, LW=2)
REQ-034 Reset, then data_in=0xA5, live_in=2'b10 for 2 cycles, enter 0->1 -> ch_ctrl[9:0]=10_1010_0101, commit_pulse high 1 cycle, dirty=0.
REQ-035 Sel ch1, data_in=0x3C, enter held 5 cycles, then data_in=0x11 -> ch1 data=0x3C, exactly one commit_pulse, dirty=1, ch0 unchanged 0xA5.
REQ-036 sel_valid=1, sel_idx=1 with enter rising same cycle -> active=1, no commit, commit_pulse stays 0.
REQ-037 commit_all=1, stage ch0=0x01, ch1=0x02, enter edge -> both committed simultaneously, single commit_pulse.
REQ-038 NCH=3 build, sel_idx=3 -> active unchanged, status[CW+RW-1:RW] unchanged.
REQ-039 Reset asserted mid-operation with nonzero registers -> all outputs 0 next cycle; status reads 0.
